// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types for the UART receive slice.
// Frame states, parity modes, FIFO entry layout, majority helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int MAX_DATA_BITS = 9;

  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// uart_rx_fifo_buf: first-word-fall-through FIFO with occupancy.
// A push into a full FIFO is taken only when a pop frees the slot.
module uart_rx_fifo_buf #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             wr_en, rd_en;

  // pointer, occupancy and storage update
  always_comb begin
    full     = (level_q == FULL_LVL);
    empty    = (level_q == '0);
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  // state registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with glitch/parity/framing/break checks.
// Define UART_RX_MAJORITY_EN for 2-of-3 mid-bit voting.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 106,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_frame_err,
  output logic                        m_parity_err,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        overflow,
  input  logic                        clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int IW    = 4;
  localparam int WIDTH = DATA_BITS + 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_CNT = CLKS_PER_BIT / 2;
`else
  localparam int START_CNT = CLKS_PER_BIT / 2 - 1;
`endif
  localparam logic [CW-1:0] START_RELOAD = CW'(START_CNT);
  localparam logic [CW-1:0] BIT_RELOAD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST    = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST    = IW'(STOP_BITS - 1);

  logic sync1_q, sync1_d;
  logic rx_s_q, rx_s_d;
  logic rx_prev_q, rx_prev_d;
  logic fall, bit_s;

  // two-flop synchroniser plus one history flop for edge detect
  always_comb begin
    sync1_d   = rx;
    rx_s_d    = sync1_q;
    rx_prev_d = rx_s_q;
  end

  // synchroniser registers idle high
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  assign fall = rx_prev_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2_q;

  // extra history flop so mid-1, mid, mid+1 are visible together
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rx_prev2_q <= 1'b1;
    else          rx_prev2_q <= rx_prev_q;
  end

  assign bit_s = maj3(rx_prev2_q, rx_prev_q, rx_s_q);
`else
  assign bit_s = rx_s_q;
`endif

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 overflow_q, overflow_d;
  logic                 tick, fe, push;
  rx_entry_t            push_e;

  assign tick = (cnt_q == '0);

  // frame sequencer: next state, sampling and push request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    push      = 1'b0;
    push_e    = '0;
    fe        = frm_err_q | ~bit_s;
    if (!tick) cnt_d = cnt_q - CW'(1);
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          cnt_d     = START_RELOAD;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          cnt_d = BIT_RELOAD;
          idx_d = DATA_LAST;
          state_d = bit_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = BIT_RELOAD;
          shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
          idx_d   = idx_q - IW'(1);
          if (idx_q == '0) begin
            idx_d   = STOP_LAST;
            state_d = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d   = BIT_RELOAD;
          state_d = STOP;
          if (PARITY_MODE == PAR_ODD)
            par_err_d = ~(^{shreg_q, bit_s});
          else
            par_err_d = ^{shreg_q, bit_s};
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d     = BIT_RELOAD;
          frm_err_d = fe;
          idx_d     = idx_q - IW'(1);
          if (idx_q == '0) begin
            push              = 1'b1;
            push_e.frame_err  = fe;
            push_e.parity_err = par_err_q;
            push_e.data       = MAX_DATA_BITS'(shreg_q);
            state_d           = fe ? BREAK : IDLE;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // sequencer registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  logic [WIDTH-1:0] wdata, rdata;
  logic             full, empty, pop, drop;
  logic             unused_hi;

  assign wdata = {push_e.frame_err, push_e.parity_err,
                  push_e.data[DATA_BITS-1:0]};
  assign unused_hi = ^push_e.data;
  assign pop  = m_valid & m_ready;
  assign drop = push & full & ~pop;

  uart_rx_fifo_buf #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk     (clk),
    .aresetn (aresetn),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // sticky overflow; a same-cycle drop beats the clear
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  // overflow register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign m_valid      = ~empty;
  assign m_data       = rdata[DATA_BITS-1:0];
  assign m_parity_err = rdata[DATA_BITS];
  assign m_frame_err  = rdata[DATA_BITS+1];
  assign overflow     = overflow_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames against a queue-based model.
// Main DUT is 8N1; two side DUTs cover 8E1 and 8O1.
module tb_uart_rx_fifo;

  localparam int C     = 106;
  localparam int DEPTH = 16;
  localparam int LAT   = 2 + C / 2 + (8 + 1) * C + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       aresetn, rx, m_ready, clear_overflow;
  logic [7:0] m_data;
  logic       m_frame_err, m_parity_err, m_valid, overflow, busy;
  logic [4:0] fifo_level;

  logic       rx_p, ready_p;
  logic [7:0] data_e, data_o;
  logic       fe_e, pe_e, v_e, ovf_e, busy_e;
  logic       fe_o, pe_o, v_o, ovf_o, busy_o;
  logic [2:0] lvl_e, lvl_o;

  uart_rx_fifo #(
    .CLKS_PER_BIT (C), .DATA_BITS (8), .PARITY_MODE (0),
    .STOP_BITS (1), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .aresetn (aresetn), .rx (rx),
    .m_data (m_data), .m_frame_err (m_frame_err),
    .m_parity_err (m_parity_err), .m_valid (m_valid),
    .m_ready (m_ready), .overflow (overflow),
    .clear_overflow (clear_overflow),
    .fifo_level (fifo_level), .busy (busy)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT (C), .DATA_BITS (8), .PARITY_MODE (2),
    .STOP_BITS (1), .FIFO_DEPTH (4)
  ) dut_e (
    .clk (clk), .aresetn (aresetn), .rx (rx_p),
    .m_data (data_e), .m_frame_err (fe_e),
    .m_parity_err (pe_e), .m_valid (v_e),
    .m_ready (ready_p), .overflow (ovf_e),
    .clear_overflow (1'b0),
    .fifo_level (lvl_e), .busy (busy_e)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT (C), .DATA_BITS (8), .PARITY_MODE (1),
    .STOP_BITS (1), .FIFO_DEPTH (4)
  ) dut_o (
    .clk (clk), .aresetn (aresetn), .rx (rx_p),
    .m_data (data_o), .m_frame_err (fe_o),
    .m_parity_err (pe_o), .m_valid (v_o),
    .m_ready (ready_p), .overflow (ovf_o),
    .clear_overflow (1'b0),
    .fifo_level (lvl_o), .busy (busy_o)
  );

  typedef struct {
    longint     due;
    logic [9:0] e;
  } sched_t;

  sched_t     pend[$];
  logic [9:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       popped, was_full;
  longint     cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // model: frames land in the queue at their due cycle
  always @(posedge clk) begin
    cyc++;
    if (!aresetn) begin
      mq.delete();
      pend.delete();
      m_ovf = 1'b0;
    end else begin
      popped   = (mq.size() > 0) && m_ready;
      was_full = (mq.size() == DEPTH);
      if (clear_overflow) m_ovf = 1'b0;
      if (popped) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (!was_full || popped) mq.push_back(pend[0].e);
        else m_ovf = 1'b1;
        void'(pend.pop_front());
      end
    end
  end

  // compare every cycle while out of reset
  always @(negedge clk) begin
    if (started && aresetn === 1'b1) begin
      chk("valid", 32'(m_valid), 32'(mq.size() > 0));
      chk("level", 32'(fifo_level), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0)
        chk("head", 32'({m_frame_err, m_parity_err, m_data}),
            32'(mq[0]));
    end
  end

  task automatic send(input logic [7:0] d, input logic stop);
    pend.push_back('{due: cyc + LAT, e: {~stop, 1'b0, d}});
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_p(input logic [7:0] d, input logic p);
    rx_p = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_p = d[i];
      repeat (C) @(negedge clk);
    end
    rx_p = p;
    repeat (C) @(negedge clk);
    rx_p = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  task automatic pop_main();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    rx = 1'b1;
    rx_p = 1'b1;
    m_ready = 1'b0;
    ready_p = 1'b0;
    clear_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_flags", 32'({m_frame_err, m_parity_err}), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    aresetn = 1'b1;
    started = 1'b1;
    repeat (5) @(negedge clk);

    fork
      send(8'h55, 1'b1);
      begin
        repeat (1009) @(negedge clk);
        chk("lat_early", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(m_valid), 32'd1);
        chk("lat_data", 32'(m_data), 32'h55);
        chk("lat_flags", 32'({m_frame_err, m_parity_err}), 32'd0);
        chk("lat_level", 32'(fifo_level), 32'd1);
      end
    join
    pop_main();
    chk("pop_level", 32'(fifo_level), 32'd0);

    send_p(8'hA3, 1'b0);
    send_p(8'hA3, 1'b1);
    repeat (5) @(negedge clk);
    chk("e_level", 32'(lvl_e), 32'd2);
    chk("e_data", 32'(data_e), 32'hA3);
    chk("e_pe0", 32'(pe_e), 32'd0);
    chk("o_pe0", 32'(pe_o), 32'd1);
    chk("o_valid", 32'(v_o), 32'd1);
    chk("eo_fe", 32'({fe_e, fe_o}), 32'd0);
    ready_p = 1'b1;
    @(negedge clk);
    ready_p = 1'b0;
    chk("e_pe1", 32'(pe_e), 32'd1);
    chk("o_pe1", 32'(pe_o), 32'd0);
    chk("o_data", 32'(data_o), 32'hA3);
    chk("eo_level", 32'({lvl_e, lvl_o}), 32'({3'd1, 3'd1}));
    chk("eo_misc", 32'({v_e, ovf_e, ovf_o, busy_e, busy_o}),
        32'b10000);

    fork
      begin
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
      end
      begin
        repeat (20) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'd1);
        repeat (40) @(negedge clk);
        chk("glitch_idle", 32'(busy), 32'd0);
      end
    join
    repeat (200) @(negedge clk);
    chk("glitch_level", 32'(fifo_level), 32'd0);

    for (int i = 0; i < 17; i++) send(8'(i), 1'b1);
    repeat (20) @(negedge clk);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(m_data), 32'(i));
      m_ready = 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b0;
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    send(8'h7E, 1'b0);
    fork
      begin
        repeat (3000) @(negedge clk);
        rx = 1'b1;
      end
      begin
        repeat (1500) @(negedge clk);
        chk("brk_busy", 32'(busy), 32'd1);
        chk("brk_level", 32'(fifo_level), 32'd1);
      end
    join
    repeat (20) @(negedge clk);
    chk("brk_fe", 32'(m_frame_err), 32'd1);
    chk("brk_data", 32'(m_data), 32'h7E);
    chk("brk_idle", 32'(busy), 32'd0);
    pop_main();
    send(8'h31, 1'b1);
    repeat (20) @(negedge clk);
    chk("rec_data", 32'(m_data), 32'h31);
    chk("rec_fe", 32'(m_frame_err), 32'd0);
    chk("rec_level", 32'(fifo_level), 32'd1);
    pop_main();

    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    repeat (5) @(negedge clk);
    chk("pre_level", 32'(fifo_level), 32'd3);
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (300) @(negedge clk);
        chk("pre_busy", 32'(busy), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("ar_level", 32'(fifo_level), 32'd0);
        chk("ar_valid", 32'(m_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    chk("post_level", 32'(fifo_level), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    send(8'h42, 1'b1);
    repeat (20) @(negedge clk);
    chk("post_data", 32'(m_data), 32'h42);
    chk("post_cnt", 32'(fifo_level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
